rx_text_writer: RTL

RX_TEXT_WRITER -- requirements
Module: rx_text_writer

---
 rtl/rx_text_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rx_text_writer.sv
// UART byte stream to text-RAM writer: 4-entry FIFO, cursor control, screen/row clears.
// Cell write is visible 2 cycles after the byte's strobe; a full FIFO drops bytes and sets the sticky overflow.
module rx_text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int FIFO_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  din,
  input  logic        ovf_clr,
  output logic        we,
  output logic [11:0] addr,
  output logic [7:0]  wdata,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy,
  output logic        overflow
);

  localparam int          DEPTH  = 1 << FIFO_W;
  localparam logic [11:0] TOTAL  = 12'(COLS * ROWS);
  localparam logic [11:0] COLS12 = 12'(COLS);
  localparam logic [7:0]  SPACE  = 8'h20;

  typedef enum logic [1:0] {CLR_ALL, IDLE, EXEC, CLR_ROW} state_t;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_W:0]   count_q;
  logic              ovf_q;
  logic [7:0]        cmd_q, cmd_d;
  logic [6:0]        cur_x_q, cur_x_d;
  logic [4:0]        cur_y_q, cur_y_d;
  logic [11:0]       cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [11:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic        full, empty, pop, push_ok, drop;
  logic [7:0]  head;
  logic [11:0] row_base;
  logic        newline;
  logic [4:0]  next_y;

  assign full    = (count_q == (FIFO_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == IDLE) && !empty;
  // A full FIFO still takes a byte when the FSM pops in the same cycle.
  assign push_ok = rx_done_tick && (!full || pop);
  assign drop    = rx_done_tick && full && !pop;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_ALL;
      cmd_q   <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Cell writes are decoded at pop time so they register one cycle later;
  // the cursor and any row clear are resolved in EXEC from the stored byte.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    newline  = 1'b0;
    row_base = 12'(cur_y_q) * COLS12;
    next_y   = (cur_y_q == 5'(ROWS - 1)) ? 5'd0 : cur_y_q + 5'd1;
    case (state_q)
      CLR_ALL: begin
        if (cnt_q != TOTAL) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = SPACE;
          cnt_d   = cnt_q + 12'd1;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!empty) begin
          cmd_d   = head;
          state_d = EXEC;
          if (is_print(head)) begin
            we_d    = 1'b1;
            addr_d  = row_base + 12'(cur_x_q);
            wdata_d = head;
          end else if (head == 8'h08 && cur_x_q != 7'd0) begin
            we_d    = 1'b1;
            addr_d  = row_base + 12'(cur_x_q) - 12'd1;
            wdata_d = SPACE;
          end
        end
      end
      EXEC: begin
        if (is_print(cmd_q)) begin
          if (cur_x_q == 7'(COLS - 1)) newline = 1'b1;
          else                         cur_x_d = cur_x_q + 7'd1;
        end else if (cmd_q == 8'h0D) begin
          cur_x_d = 7'd0;
        end else if (cmd_q == 8'h0A) begin
          newline = 1'b1;
        end else if (cmd_q == 8'h08 && cur_x_q != 7'd0) begin
          cur_x_d = cur_x_q - 7'd1;
        end
        if (newline) begin
          cur_x_d = 7'd0;
          cur_y_d = next_y;
          state_d = CLR_ROW;
          we_d    = 1'b1;
          addr_d  = 12'(next_y) * COLS12;
          wdata_d = SPACE;
          cnt_d   = 12'd1;
        end else begin
          state_d = IDLE;
        end
      end
      CLR_ROW: begin
        if (cnt_q != COLS12) begin
          we_d    = 1'b1;
          addr_d  = row_base + cnt_q;
          wdata_d = SPACE;
          cnt_d   = cnt_q + 12'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = CLR_ALL;
    endcase
  end

  assign we       = we_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
  assign busy     = (state_q == CLR_ALL) || (state_q == CLR_ROW);
  assign overflow = ovf_q;

endmodule
